// File: rtl/drum_arbiter.sv
// Round-robin arbiter sharing one DRUM approximate signed multiplier across NREQ requesters.
// Optional feature: define DRUM_ARB_OPCOUNT_EN to build the 16-bit accepted-operation counter.

module drum #(
    parameter int K = 6,
    parameter int N = 4,
    parameter int M = 4
) (
    input  logic [N-1:0]   a,
    input  logic [M-1:0]   b,
    output logic [N+M-1:0] r
);
    logic [N-1:0]   mag_a;
    logic [N-1:0]   trunc_a;
    logic [M-1:0]   mag_b;
    logic [M-1:0]   trunc_b;
    int             sh_a;
    int             sh_b;
    logic [N+M-1:0] prod;

    // Keep the K bits from the leading one down and force the kept LSB to 1 (unbiased truncation).
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        mag_a = a[N-1] ? ~a : a;
        sh_a  = 0;
        for (int i = K; i < N; i++) begin
            if (mag_a[i]) sh_a = i - K + 1;
        end
        trunc_a = (sh_a > 0) ? ((mag_a >> sh_a) | N'(1)) : mag_a;
    end

    always_comb begin
        mag_b = b[M-1] ? ~b : b;
        sh_b  = 0;
        for (int i = K; i < M; i++) begin
            if (mag_b[i]) sh_b = i - K + 1;
        end
        trunc_b = (sh_b > 0) ? ((mag_b >> sh_b) | M'(1)) : mag_b;
    end

    always_comb begin
        prod = ((N+M)'(trunc_a) * (N+M)'(trunc_b)) << (sh_a + sh_b);
        r    = (a[N-1] ^ b[M-1]) ? ~prod : prod;
    end
endmodule

module drum_arbiter #(
    parameter int NREQ = 4,
    parameter int K    = 6,
    parameter int N    = 4,
    parameter int M    = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*N-1:0]   req_a,
    input  logic [NREQ*M-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [N+M-1:0]      rsp_r,
    output logic [15:0]         op_count
);
    logic            s1_valid;
    logic [ID_W-1:0] s1_id;
    logic [N-1:0]    s1_a;
    logic [M-1:0]    s1_b;
    logic            s2_valid;
    logic [ID_W-1:0] s2_id;
    logic [N+M-1:0]  s2_r;
    logic [ID_W-1:0] last;
    logic [ID_W-1:0] winner;
    logic            found;
    logic            s1_adv;
    logic            s2_adv;
    logic            grant;
    logic [N+M-1:0]  drum_r;

    assign s2_adv = !s2_valid || rsp_ready;
    assign s1_adv = !s1_valid || s2_adv;

    always_comb begin : arbitrate
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last) + i) % NREQ;
            if (!found && req_valid[ID_W'(idx)]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    // Ready is held low while reset is asserted so no handshake is visible during reset.
    assign grant     = !rst && s1_adv && found;
    assign req_ready = grant ? (NREQ'(1) << winner) : '0;

    drum #(.K(K), .N(N), .M(M)) u_drum (
        .a (s1_a),
        .b (s1_b),
        .r (drum_r)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            last     <= ID_W'(NREQ - 1);
        end else if (s1_adv) begin
            s1_valid <= grant;
            if (grant) begin
                s1_id <= winner;
                s1_a  <= req_a[winner*N +: N];
                s1_b  <= req_b[winner*M +: M];
                last  <= winner;
            end
        end
    end

    // Payload only moves with a valid product so rsp_id/rsp_r never change on a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_id    <= '0;
            s2_r     <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_id <= s1_id;
                s2_r  <= drum_r;
            end
        end
    end

    assign rsp_valid = s2_valid;
    assign rsp_id    = s2_id;
    assign rsp_r     = s2_r;

`ifdef DRUM_ARB_OPCOUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else if (grant) count_q <= count_q + 16'd1;
    end

    assign op_count = count_q;
`else
    assign op_count = 16'd0;
`endif
endmodule

// File: tb/tb_drum_arbiter.sv
// Directed self-checking bench for drum_arbiter at default parameters (NREQ=4, K=6, N=4, M=4).
`timescale 1ns/1ps

module tb_drum_arbiter;
`ifdef DRUM_ARB_OPCOUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_r;
    logic [15:0] op_count;

    int total = 0;
    int bad   = 0;

    // Stream operands per requester (3..0).
    logic [15:0] stream_a = {4'hC, 4'h7, 4'hA, 4'h3};
    logic [15:0] stream_b = {4'h5, 4'hE, 4'h6, 4'h2};

    drum_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_r     (rsp_r),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    // Widths fit inside K, so DRUM is exact: one's-complement sign-magnitude product.
    function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] ma;
        logic [3:0] mb;
        logic [7:0] p;
        ma = a[3] ? ~a : a;
        mb = b[3] ? ~b : b;
        p  = {4'b0, ma} * {4'b0, mb};
        return (a[3] ^ b[3]) ? ~p : p;
    endfunction

    function automatic logic [15:0] cnt_exp(input int n);
        return CNT_EN ? 16'(n) : 16'd0;
    endfunction

    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'hF;
        @(negedge clk);
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
        total++; if (rsp_r !== 8'h00) begin bad++; $display("FAIL reset_rsp_r got=%h exp=00", rsp_r); end
        total++; if (op_count !== 16'd0) begin bad++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One isolated handshake; called at a negedge with an idle pipeline.
    task automatic run_one(input int id, input logic [3:0] a, input logic [3:0] b,
                           input logic [7:0] exp_r, input int n_ops, input string name);
        req_valid        = 4'(1 << id);
        req_a            = '0;
        req_b            = '0;
        req_a[id*4 +: 4] = a;
        req_b[id*4 +: 4] = b;
        #1;
        total++; if (req_ready !== 4'(1 << id)) begin bad++; $display("FAIL %s_ready got=%b exp=%b", name, req_ready, 4'(1 << id)); end
        @(negedge clk);
        req_valid = '0;
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL %s_early_valid got=%b exp=0", name, rsp_valid); end
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL %s_valid got=%b exp=1", name, rsp_valid); end
        total++; if (rsp_id !== 2'(id)) begin bad++; $display("FAIL %s_id got=%0d exp=%0d", name, rsp_id, id); end
        total++; if (rsp_r !== exp_r) begin bad++; $display("FAIL %s_r got=%h exp=%h", name, rsp_r, exp_r); end
        total++; if (op_count !== cnt_exp(n_ops)) begin bad++; $display("FAIL %s_count got=%0d exp=%0d", name, op_count, cnt_exp(n_ops)); end
        @(negedge clk);
    endtask

    task automatic test_single();
        run_one(2, 4'h3, 4'h5, 8'h0F, 1, "single");
    endtask

    task automatic test_negative();
        run_one(0, 4'hE, 4'h3, 8'hFC, 2, "neg_e3");
        run_one(1, 4'hF, 4'h2, 8'hFF, 3, "neg_f2");
    endtask

    task automatic test_round_robin();
        int g;
        apply_reset();
        req_a     = stream_a;
        req_b     = stream_b;
        req_valid = 4'hF;
        for (int k = 0; k < 20; k++) begin
            #1;
            total++; if (req_ready !== 4'(1 << (k % 4))) begin bad++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % 4))); end
            if (k >= 2) begin
                g = (k - 2) % 4;
                total++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'(g) || rsp_r !== ref_mul(stream_a[g*4 +: 4], stream_b[g*4 +: 4])) begin
                    bad++;
                    $display("FAIL rr_rsp k=%0d got=%b/%0d/%h exp=1/%0d/%h", k, rsp_valid, rsp_id, rsp_r,
                             g, ref_mul(stream_a[g*4 +: 4], stream_b[g*4 +: 4]));
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
        #1;
        total++; if (op_count !== cnt_exp(20)) begin bad++; $display("FAIL rr_count got=%0d exp=%0d", op_count, cnt_exp(20)); end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        logic [3:0] exp_ready;
        int         exp_id;
        apply_reset();
        req_a     = stream_a;
        req_b     = stream_b;
        req_valid = 4'hF;
        for (int k = 0; k < 11; k++) begin
            rsp_ready = (k >= 7);
            #1;
            if (k == 0)      exp_ready = 4'b0001;
            else if (k == 1) exp_ready = 4'b0010;
            else if (k < 7)  exp_ready = 4'b0000;
            else             exp_ready = 4'(1 << ((k - 5) % 4));
            total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL bp_ready k=%0d got=%b exp=%b", k, req_ready, exp_ready); end
            if (k < 2) begin
                total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_idle k=%0d got=%b exp=0", k, rsp_valid); end
            end else begin
                exp_id = (k <= 7) ? 0 : k - 7;
                total++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id) ||
                    rsp_r !== ref_mul(stream_a[exp_id*4 +: 4], stream_b[exp_id*4 +: 4])) begin
                    bad++;
                    $display("FAIL bp_rsp k=%0d got=%b/%0d/%h exp=1/%0d/%h", k, rsp_valid, rsp_id, rsp_r,
                             exp_id, ref_mul(stream_a[exp_id*4 +: 4], stream_b[exp_id*4 +: 4]));
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req_a     = stream_a;
        req_b     = stream_b;
        req_valid = 4'hF;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", rsp_valid); end
        total++; if (op_count !== 16'd0) begin bad++; $display("FAIL mid_rst_count got=%0d exp=0", op_count); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL mid_rst_ready got=%b exp=0000", req_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_rst_first got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_count_wrap();
        apply_reset();
        req_a     = stream_a;
        req_b     = stream_b;
        req_valid = 4'hF;
        repeat (65535) @(negedge clk);
        #1;
        total++; if (op_count !== cnt_exp(65535)) begin bad++; $display("FAIL wrap_max got=%h exp=%h", op_count, cnt_exp(65535)); end
        @(negedge clk);
        #1;
        total++; if (op_count !== 16'd0) begin bad++; $display("FAIL wrap_zero got=%h exp=0000", op_count); end
        req_valid = '0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_negative();
        test_round_robin();
        test_back_pressure();
        test_reset_mid();
        test_count_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
